// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, instruction field positions and opcode classification shared by decode_issue.
package decode_pkg;
    localparam int NUM_REGS    = 16;
    localparam int REG_W       = $clog2(NUM_REGS);
    localparam int INSTR_W     = 32;
    localparam int IMM_W       = 16;
    localparam int STALL_CNT_W = 16;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_ORR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_B   = 4'd8;
    localparam int OPC_LSB  = 28;
    localparam int DST_LSB  = 24;
    localparam int SRC1_LSB = 20;
    localparam int SRC2_LSB = 16;
    localparam int IMM_LSB  = 0;
    typedef struct packed {
        logic [3:0] op;
        logic       u1;
        logic       u2;
        logic       we;
    } op_class_t;
    // Opcodes above OP_B are folded into NOP so the rest of the pipe never sees them.
    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t c;
        c.op = (op > OP_B) ? OP_NOP : op;
        c.u1 = c.op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV, OP_LDR, OP_STR};
        c.u2 = c.op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_STR};
        c.we = c.op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV, OP_LDR};
        return c;
    endfunction
endpackage

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard: pending-write bits and RAW/WAW hazard detection.
// With WB_BYPASS_EN a register being written back this cycle no longer counts as pending.
module decode_issue_scoreboard
    import decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set,
    input  logic [REG_W-1:0] i_set_idx,
    input  logic             i_wb,
    input  logic [REG_W-1:0] i_wb_idx,
    input  logic             i_fl,
    input  logic [REG_W-1:0] i_fl_idx,
    input  logic             i_u1,
    input  logic [REG_W-1:0] i_s1,
    input  logic             i_u2,
    input  logic [REG_W-1:0] i_s2,
    input  logic             i_we,
    input  logic [REG_W-1:0] i_dst,
    output logic             o_hazard
);
    localparam logic [NUM_REGS-1:0] ONE = 1;
    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_wb_mask, w_clr, w_set, w_chk;
    always_comb begin
        w_wb_mask = i_wb ? ONE << i_wb_idx : '0;
        w_clr     = w_wb_mask | (i_fl ? ONE << i_fl_idx : '0);
        w_set     = i_set ? ONE << i_set_idx : '0;
`ifdef WB_BYPASS_EN
        w_chk     = r_pending & ~w_wb_mask;
`else
        w_chk     = r_pending;
`endif
        o_hazard  = (i_u1 && w_chk[i_s1]) || (i_u2 && w_chk[i_s2]) || (i_we && w_chk[i_dst]);
    end
    // Clears applied first so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~w_clr) | w_set;
    end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: decodes instructions into register-bank fields and issues them through one
// registered valid/ready stage, stalling on scoreboard hazards. Optional macro: WB_BYPASS_EN.
module decode_issue
    import decode_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_W-1:0]     instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [3:0]             opcode,
    output logic [REG_W-1:0]       Dest,
    output logic [REG_W-1:0]       Source1,
    output logic [REG_W-1:0]       Source2,
    output logic [IMM_W-1:0]       imm,
    output logic                   out_we,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_dest,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;
    op_class_t        w_cls;
    logic [REG_W-1:0] w_dst, w_s1, w_s2;
    logic             w_hazard, w_accept;
    logic             r_out_valid, r_out_we;
    logic [3:0]       r_opcode;
    logic [REG_W-1:0] r_dest, r_src1, r_src2;
    logic [IMM_W-1:0] r_imm;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    always_comb begin
        w_cls       = classify(instr_in[OPC_LSB +: 4]);
        w_dst       = instr_in[DST_LSB +: REG_W];
        w_s1        = instr_in[SRC1_LSB +: REG_W];
        w_s2        = instr_in[SRC2_LSB +: REG_W];
        instr_ready = !rst && !flush && !w_hazard && (!r_out_valid || out_ready);
        w_accept    = instr_valid && instr_ready;
    end
    decode_issue_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_accept && w_cls.we),
        .i_set_idx (w_dst),
        .i_wb      (wb_valid),
        .i_wb_idx  (wb_dest),
        .i_fl      (flush && r_out_valid && r_out_we),
        .i_fl_idx  (r_dest),
        .i_u1      (w_cls.u1),
        .i_s1      (w_s1),
        .i_u2      (w_cls.u2),
        .i_s2      (w_s2),
        .i_we      (w_cls.we),
        .i_dst     (w_dst),
        .o_hazard  (w_hazard)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_opcode    <= '0;
            r_dest      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_imm       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_we    <= w_cls.we;
                r_opcode    <= w_cls.op;
                r_dest      <= w_dst;
                r_src1      <= w_s1;
                r_src2      <= w_s2;
                r_imm       <= instr_in[IMM_LSB +: IMM_W];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (instr_valid && w_hazard && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end
    assign out_valid = r_out_valid;
    assign out_we    = r_out_we;
    assign opcode    = r_opcode;
    assign Dest      = r_dest;
    assign Source1   = r_src1;
    assign Source2   = r_src2;
    assign imm       = r_imm;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed and random stimulus against a behavioural model, with a queue-based
// output monitor. Follows WB_BYPASS_EN the same way as the design.
module tb_decode_issue;
    logic        clk = 0, rst = 1;
    logic [31:0] instr_in = 0;
    logic        instr_valid = 0, out_ready = 0, wb_valid = 0, flush = 0;
    logic [3:0]  wb_dest = 0;
    logic        instr_ready, out_valid, out_we;
    logic [3:0]  opcode, Dest, Source1, Source2;
    logic [15:0] imm, stall_cnt;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .out_ready(out_ready), .out_valid(out_valid),
        .opcode(opcode), .Dest(Dest), .Source1(Source1), .Source2(Source2), .imm(imm),
        .out_we(out_we), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
        .stall_cnt(stall_cnt)
    );

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1;
`else
    localparam bit BYP = 0;
`endif

    typedef struct {
        logic [3:0]  op, d, s1, s2;
        logic [15:0] imm;
        logic        we;
    } exp_t;

    exp_t        q[$];
    bit          pend[16];
    bit          m_valid, m_we, m_acc, m_haz;
    logic [3:0]  m_dest;
    int unsigned m_stall;
    int          checks = 0, errors = 0;

    function automatic bit uses1(input logic [3:0] op); return op >= 1 && op <= 7; endfunction
    function automatic bit uses2(input logic [3:0] op); return (op >= 1 && op <= 4) || op == 7; endfunction
    function automatic bit writes(input logic [3:0] op); return op >= 1 && op <= 6; endfunction
    function automatic bit busy(input logic [3:0] r);
        return pend[r] && !(BYP && wb_valid && wb_dest == r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance the model over the clock edge that just happened, using the inputs held during it.
    task automatic model_update();
        logic [3:0] op;
        exp_t e;
        op = instr_in[31:28];
        if (rst) begin
            pend = '{default: 0};
            m_valid = 0;
            m_stall = 0;
            q.delete();
        end else begin
            if (instr_valid && m_haz && m_stall < 65535) m_stall++;
            if (flush && m_valid && m_we) pend[m_dest] = 0;
            if (wb_valid) pend[wb_dest] = 0;
            if (m_acc && writes(op)) pend[instr_in[27:24]] = 1;
            if (flush) begin
                if (m_valid && q.size() > 0) void'(q.pop_front());
                m_valid = 0;
            end else if (m_acc) begin
                e.op = (op > 8) ? 4'd0 : op;
                e.d = instr_in[27:24];
                e.s1 = instr_in[23:20];
                e.s2 = instr_in[19:16];
                e.imm = instr_in[15:0];
                e.we = writes(op);
                q.push_back(e);
                m_valid = 1;
                m_we = e.we;
                m_dest = e.d;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_cycle();
        logic [3:0] op;
        bit rdy;
        op = instr_in[31:28];
        m_haz = (uses1(op) && busy(instr_in[23:20])) || (uses2(op) && busy(instr_in[19:16])) ||
                (writes(op) && busy(instr_in[27:24]));
        rdy = !rst && !flush && !m_haz && (!m_valid || out_ready);
        m_acc = instr_valid && rdy;
        chk("instr_ready", instr_ready, rdy);
        chk("out_valid", out_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit ordy,
                        input bit wbv, input logic [3:0] wbd, input bit fl);
        @(posedge clk);
        model_update();
        #1;
        rst = r; instr_valid = iv; instr_in = ins; out_ready = ordy;
        wb_valid = wbv; wb_dest = wbd; flush = fl;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drain();
        for (int r = 0; r < 16; r++) step(0, 0, 0, 1, 1, r[3:0], 0);
    endtask

    // Monitor: every presented output must equal the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out at %0t: out_valid=1 with nothing expected", $time);
            end else begin
                chk("opcode", opcode, q[0].op);
                chk("Dest", Dest, q[0].d);
                chk("Source1", Source1, q[0].s1);
                chk("Source2", Source2, q[0].s2);
                chk("imm", imm, q[0].imm);
                chk("out_we", out_we, q[0].we);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ins;
        bit ordy, fl;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_Dest", Dest, 0);
        chk("rst_Source1", Source1, 0);
        chk("rst_Source2", Source2, 0);
        chk("rst_imm", imm, 0);
        chk("rst_out_we", out_we, 0);
        // ADD r3 then dependent SUB r4,r3,r5 released by writeback of r3
        step(0, 1, 32'h1312_0000, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h2435_0000, 1, 0, 0, 0);
        step(0, 1, 32'h2435_0000, 1, 1, 4'd3, 0);
        step(0, !m_acc, 32'h2435_0000, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        drain();
        // backpressure: held output must stay stable
        step(0, 1, 32'h5A90_00AA, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h5B90_00BB, 0, 0, 0, 0);
        step(0, 1, 32'h5B90_00BB, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        drain();
        // accept MOV r6 while r6 is written back: set wins, reader of r6 stalls
        step(0, 1, 32'h5690_0000, 1, 1, 4'd6, 0);
        step(0, 1, 32'h1167_0000, 1, 0, 0, 0);
        step(0, 1, 32'h1167_0000, 1, 0, 0, 0);
        drain();
        // flush a held LDR r7: STR r7,r8 issues without stall
        step(0, 1, 32'h6790_0000, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h7078_0000, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        drain();
        // undefined opcode with sources on a pending register decodes as NOP
        step(0, 1, 32'h1312_0000, 1, 0, 0, 0);
        step(0, 1, 32'hB333_1234, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        // reset in the middle of a held transfer
        step(0, 1, 32'h1512_0000, 0, 0, 0, 0);
        step(1, 1, 32'h1612_0000, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("midrst_stall", stall_cnt, 0);
        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            ins = {4'($urandom_range(0, 15)), 1'b0, 3'($urandom), 1'b0, 3'($urandom),
                   1'b0, 3'($urandom), 16'($urandom)};
            fl = ($urandom_range(0, 19) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
            step(0, $urandom_range(0, 9) < 7, ins, ordy, $urandom_range(0, 9) < 4,
                 4'($urandom_range(0, 7)), fl);
        end
        drain();
        step(0, 0, 0, 1, 0, 0, 0);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
